seq_mult_controller: RTL and testbench

Sequential shift-and-add unsigned multiplier controller. It time-multiplexes a single `nBitAdder_module` instance over N iterations to form a 2N-bit product. It sits beside the ALU datapath as the multi-cycle multiply unit, started by a one-cycle `start` and reporting through `busy`/`done`. Flags follow the adder's bit encoding so downstream flag logic is shared.

---
 rtl/mult_ctrl_pkg.sv | 18 +
 rtl/seq_mult_controller_adder.sv | 26 ++
 rtl/seq_mult_controller.sv | 104 ++++++++++
 tb/tb_seq_mult_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential multiplier controller.
//   state_t   : controller FSM states
//   FLAG_ZERO : flag bit index, result is zero
//   FLAG_OVF  : flag bit index, overflow / carry out
// Adder flag consumers use the same bit indices, so downstream flag
// logic can be shared between the adder and the multiplier.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;

endpackage

// File: rtl/seq_mult_controller_adder.sv
// Combinational N-bit unsigned adder with status flags.
//   x, y  : N-bit unsigned addends
//   sum   : N-bit sum (carry out dropped)
//   flags : [FLAG_ZERO] sum == 0, [FLAG_OVF] carry out, [3:2] zero
module nBitAdder_module
  import mult_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic [3:0]   flags
);

  logic [N:0] wide;

  always_comb begin
    wide             = (N+1)'(x) + (N+1)'(y);
    sum              = wide[N-1:0];
    flags            = '0;
    flags[FLAG_ZERO] = (wide[N-1:0] == '0);
    flags[FLAG_OVF]  = wide[N];
  end

endmodule

// File: rtl/seq_mult_controller.sv
// Shift-and-add unsigned multiplier controller. One adder is reused over
// N iterations to build a 2N-bit product.
//   clk, rst : clock, async active-high reset
//   start    : request a multiply, sampled only in IDLE
//   a, b     : multiplicand / multiplier, latched on accepted start
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse while in DONE
//   product  : registered 2N-bit result, held until next completion
//   flags    : registered status, [0] zero, [1] product exceeds N bits
module seq_mult_controller
  import mult_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [3:0]     flags
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t         state, state_nxt;
  logic [N-1:0]   m, acc, q;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   addend, sum;
  logic [3:0]     add_flags;
  logic           carry;
  logic [N-1:0]   acc_nxt, q_nxt;
  logic [2*N-1:0] prod_nxt;
  logic [3:0]     flags_nxt;
  logic           last_iter;

  nBitAdder_module #(.N(N)) u_add (
    .x     (acc),
    .y     (addend),
    .sum   (sum),
    .flags (add_flags)
  );

  always_comb begin
    addend    = q[0] ? m : '0;
    carry     = add_flags[FLAG_OVF];
    // Shift the {carry, sum, q} window right by one each iteration.
    acc_nxt   = {carry, sum[N-1:1]};
    q_nxt     = {sum[0], q[N-1:1]};
    prod_nxt  = {acc_nxt, q_nxt};
    flags_nxt = '0;
    flags_nxt[FLAG_ZERO] = (prod_nxt == '0);
    flags_nxt[FLAG_OVF]  = |prod_nxt[2*N-1:N];
    last_iter = (cnt == LAST);

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
      flags   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          m   <= a;
          q   <= b;
          acc <= '0;
          cnt <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            product <= prod_nxt;
            flags   <= flags_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_controller.sv
module tb_seq_mult_controller;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a, b;
  logic           busy, done;
  logic [2*N-1:0] product;
  logic [3:0]     flags;

  int vectors = 0;
  int miss    = 0;
  logic [2*N-1:0] prev_prod = '0;

  seq_mult_controller #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start at the next edge, then follow the op to IDLE.
  task automatic run_op(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [2*N-1:0] ep, input logic [3:0] ef);
    start = 1'b1; a = ia; b = ib;
    @(posedge clk); @(negedge clk);
    start = 1'b0; a = '1; b = '1;     // later operand changes must not matter
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      check($sformatf("%s_done%0d", tag, k), 32'(done), 32'(k == N));
      if (k == N-1) check({tag, "_hold"}, 32'(product), 32'(prev_prod));
    end
    check({tag, "_prod"},  32'(product), 32'(ep));
    check({tag, "_flags"}, 32'(flags),   32'(ef));
    prev_prod = ep;
    @(posedge clk); @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_prod",  32'(product), 32'd0);
    check("rst_flags", 32'(flags),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("m3x5",   4'd3,  4'd5,  8'h0F, 4'b0000);
    run_op("m15x15", 4'd15, 4'd15, 8'hE1, 4'b0010);
    run_op("m0x9",   4'd0,  4'd9,  8'h00, 4'b0001);
    run_op("m9x0",   4'd9,  4'd0,  8'h00, 4'b0001);

    // Second start during RUN is ignored.
    start = 1'b1; a = 4'd9; b = 4'd7;
    @(posedge clk); @(negedge clk);          // E0 accepted
    start = 1'b0;
    for (int k = 1; k <= N+2; k++) begin
      start = (k == 2); a = (k == 2) ? 4'd1 : 4'd9; b = (k == 2) ? 4'd1 : 4'd7;
      @(posedge clk); @(negedge clk);
      check($sformatf("ign_done%0d", k), 32'(done), 32'(k == N));
      if (k == N) begin
        check("ign_prod",  32'(product), 32'h3F);
        check("ign_flags", 32'(flags),   32'b0010);
      end
    end
    start = 1'b0;
    prev_prod = 8'h3F;

    // Reset during the third RUN cycle aborts immediately.
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(posedge clk); @(negedge clk);          // E0
    start = 1'b0;
    @(posedge clk); @(negedge clk);          // E1
    @(posedge clk); @(negedge clk);          // E2: third RUN cycle
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(busy),    32'd0);
    check("abort_done",  32'(done),    32'd0);
    check("abort_prod",  32'(product), 32'd0);
    check("abort_flags", 32'(flags),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_prod = '0;
    @(negedge clk);
    run_op("m2x6", 4'd2, 4'd6, 8'h0C, 4'b0000);

    // Start held high: one result every N+2 cycles. 16 does not fit in 4 bits.
    start = 1'b1; a = 4'd4; b = 4'd4;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("b2b_done%0d", c), 32'(done), 32'((c % 6) == 4));
      if ((c % 6) == 4) begin
        check($sformatf("b2b_prod%0d", c),  32'(product), 32'h10);
        check($sformatf("b2b_flags%0d", c), 32'(flags),   32'b0010);
      end
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
